// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU sequencing types and constants
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } seq_state_e;

    localparam logic [3:0]  OPC_STA     = 4'b0001;
    localparam logic [15:0] INSTR_EMPTY = 16'hFFFF;

    localparam int DEF_PROG_STRIDE = 100;
    localparam int DEF_NUM_PROGS   = 10;
    localparam int DEF_TIMEOUT     = 200;

endpackage

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - runs one canned CPU program per command, returns its result
module prog_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int PROG_STRIDE = DEF_PROG_STRIDE,
    parameter int NUM_PROGS   = DEF_NUM_PROGS,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_sel,
    input  logic [15:0]     fetch_instr,
    input  logic            result_we,
    input  logic [15:0]     result_in,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_load_val,
    output logic            cpu_run,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [15:0]     rsp_data,
    output logic            rsp_err,
    output logic [7:0]      rsp_cycles
);

    localparam int CNT_W = 16;

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [PC_W-1:0]  r_pc_load_val;
    logic [15:0]      r_rsp_data;
    logic             r_rsp_err;
    logic [7:0]       r_rsp_cycles;

    logic             w_sel_ok;
    logic             w_load_base;
    logic             w_finish;
    logic             w_fin_err;
    logic [15:0]      w_fin_data;
    logic [7:0]       w_fin_cycles;

    assign w_sel_ok  = (cmd_sel != 4'd0) && ({28'd0, cmd_sel} <= 32'(NUM_PROGS));
    assign w_cnt_inc = r_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion priority: write-back, then unprogrammed fetch, then timeout, then STA detect.
    always_comb begin
        w_state_next = r_state;
        w_load_base  = 1'b0;
        w_finish     = 1'b0;
        w_fin_err    = 1'b0;
        w_fin_data   = 16'd0;
        w_fin_cycles = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_sel_ok) begin
                        w_load_base  = 1'b1;
                        w_state_next = ST_LOAD;
                    end else begin
                        w_finish     = 1'b1;
                        w_fin_err    = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_LOAD: w_state_next = ST_RUN;
            ST_RUN, ST_DRAIN: begin
                w_fin_cycles = (w_cnt_inc > 16'd255) ? 8'hFF : w_cnt_inc[7:0];
                if (result_we) begin
                    w_finish     = 1'b1;
                    w_fin_data   = result_in;
                    w_state_next = ST_RESP;
                end else if ((r_state == ST_RUN) && (fetch_instr == INSTR_EMPTY)) begin
                    w_finish     = 1'b1;
                    w_fin_err    = 1'b1;
                    w_state_next = ST_RESP;
                end else if (w_cnt_inc >= CNT_W'(TIMEOUT)) begin
                    w_finish     = 1'b1;
                    w_fin_err    = 1'b1;
                    w_state_next = ST_RESP;
                end else if ((r_state == ST_RUN) && (fetch_instr[15:12] == OPC_STA)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_pc_load_val <= '0;
            r_rsp_data    <= 16'd0;
            r_rsp_err     <= 1'b0;
            r_rsp_cycles  <= 8'd0;
        end else begin
            if (w_load_base) begin
                r_pc_load_val <= PC_W'({28'd0, cmd_sel} * 32'(PROG_STRIDE));
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= '0;
            end else if ((r_state == ST_RUN) || (r_state == ST_DRAIN)) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_finish) begin
                r_rsp_data   <= w_fin_data;
                r_rsp_err    <= w_fin_err;
                r_rsp_cycles <= w_fin_cycles;
            end
        end
    end

    // cmd_ready is gated by reset so it stays low for the whole reset window.
    assign cmd_ready   = reset && (r_state == ST_IDLE);
    assign pc_load     = (r_state == ST_LOAD);
    assign pc_load_val = r_pc_load_val;
    assign cpu_run     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign rsp_cycles  = r_rsp_cycles;

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Sequences the 16-bit pipelined CPU through the canned test programs held in instruction memory. Accepts a program-select command (typically from the UART RX path), loads the program's base PC, runs the core until the program's closing STA write-back, and returns the stored result with a cycle count and error flag on a valid/ready response port (typically to UART TX). Sits between the UART command layer and the CPU's PC/fetch stage.

## Interface
Parameters:
- PC_W, 16, PC / base-address width
- PROG_STRIDE, 100, address spacing between program slots (program n at n*PROG_STRIDE)
- NUM_PROGS, 10, highest valid select (slots 1..NUM_PROGS)
- TIMEOUT, 200, max cycles from entering RUN to completion

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; high only in IDLE
- cmd_sel  in  4  program select, valid 1..NUM_PROGS
- fetch_instr  in  16  instruction currently output by instruction memory
- result_we  in  1  datapath STA write-back strobe
- result_in  in  16  STA write-back data
- pc_load  out  1  one-cycle PC load strobe
- pc_load_val  out  PC_W  PC load value
- cpu_run  out  1  enables PC advance / pipeline
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  16  captured result (0 on error)
- rsp_err  out  1  bad select, illegal fetch, or timeout
- rsp_cycles  out  8  cycles spent in RUN+DRAIN, saturating at 255

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESP.
- IDLE: cmd_ready=1, cpu_run=0. On cmd_valid&cmd_ready: sel in 1..NUM_PROGS → LOAD, latch sel; else → RESP with rsp_err=1, rsp_data=0, rsp_cycles=0.
- LOAD: pc_load=1, pc_load_val=sel*PROG_STRIDE (sel=1 → 100, sel=10 → 1000; fits 16 bits); cycle counter cleared → RUN.
- RUN: cpu_run=1, counter +1 per cycle. fetch_instr[15:12]==4'b0001 (STA) → DRAIN. fetch_instr==16'hFFFF (unprogrammed) → RESP, err=1.
- DRAIN: cpu_run=1, fetch_instr ignored (trailing 16'hFFFF fetches behind the STA are legal), counter continues.
- In RUN or DRAIN: result_we=1 → capture result_in, err=0 → RESP. Counter reaching TIMEOUT → RESP, err=1, data=0.
- RESP: cpu_run=0, rsp_valid=1; rsp_data/err/cycles held stable until rsp_ready; on rsp_valid&rsp_ready → IDLE.
- Priority in one cycle: result_we > illegal fetch > timeout > STA detect.
- cmd_valid outside IDLE ignored (cmd_ready=0, no queuing).

## Timing
- All outputs registered or decoded from registered state; no input-to-output combinational path except cmd_ready/rsp_valid (state decode).
- Command accepted at edge T: pc_load=1 during T+1, cpu_run=1 from T+2.
- Completion event sampled at edge E: cpu_run=0 and rsp_valid=1 from E+1.
- rsp_cycles = cycles in RUN+DRAIN including completion cycle.
- Reset values (reset low at an edge): state IDLE, pc_load=0, pc_load_val=0, cpu_run=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_cycles=0, counter=0; cmd_ready=0 while reset is low, 1 on first cycle after release.
- Reset mid-RUN/DRAIN/RESP: next edge IDLE, cpu_run=0, pending response dropped.

## Structure
- Shared package (cpu_pkg): state enum, OPC_STA=4'b0001, INSTR_EMPTY=16'hFFFF, PROG_STRIDE/NUM_PROGS defaults.
- Single module; no sub-module. Base address via sel*PROG_STRIDE constant multiply (or case table in package).

## Test plan
- sel=1; model fetches STA 6 cycles into RUN, result_we with 0x0005 two cycles later → pc_load_val=100 for one cycle, rsp_data=0x0005, rsp_err=0, rsp_cycles=9.
- sel=0, then sel=11 → immediate RESP, rsp_err=1, rsp_data=0, no pc_load pulse, cpu_run never high.
- sel=10, no result_we → rsp_err=1 exactly TIMEOUT cycles after RUN entry, rsp_cycles=200.
- sel=3, fetch_instr=16'hFFFF before any STA → rsp_err=1; same 16'hFFFF after STA during DRAIN → no error, result accepted.
- rsp_ready low 10 cycles with cmd_valid pulsing → rsp fields stable, cmd_ready=0, no new LOAD; rsp_ready=1 → IDLE next edge.
- reset low for one edge in RUN → cpu_run=0, rsp_valid=0 next cycle; new sel=2 command then completes normally with pc_load_val=200.
